load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath and address width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, meaning the clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning an instruction is present in the MEM stage.
REQ-005 SHALL have ports mem_read and mem_write, input, 1 each, meaning a load or a store is requested.
REQ-006 SHALL have port funct3, input, 3, meaning the access size/sign code of the instruction.
REQ-007 SHALL have ports addr and wdata, input, XLEN each, meaning the byte address (ALU result) and the store data (rs2).
REQ-008 SHALL have port stall, output, 1, meaning hold the IF/ID/EX/MEM stages and keep all inputs stable.
REQ-009 SHALL have ports out_valid (1), rdata (XLEN) and access_err (1), output, meaning a result is ready, the extended load data, and an illegal or misaligned access.
REQ-010 SHALL have ports dmem_req, dmem_we (1 each), dmem_addr (XLEN), dmem_wdata (XLEN) and dmem_be (4), output, meaning the memory request and its fields.
REQ-011 SHALL have ports dmem_ack (1) and dmem_rdata (XLEN), input, meaning request completion and the raw read word.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL define start = in_valid & (mem_read | mem_write) & !access_err, evaluated in IDLE only.
REQ-014 SHALL treat mem_read & mem_write as a load; the write is ignored.
REQ-015 SHALL assert access_err combinationally in IDLE for: a load with funct3 in {011,110,111}; a store with funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-016 SHALL, in IDLE with start, transition to BUSY and drive dmem_req=1 in that same cycle.
REQ-017 SHALL drive dmem_addr={addr[31:2],2'b00}, dmem_we=(store), and hold all dmem_* fields stable while dmem_req=1.
REQ-018 SHALL set dmem_be to 0001<<addr[1:0] for byte, 0011 or 1100 (by addr[1]) for half, 1111 for word, and 0000 for loads.
REQ-019 SHALL drive store data on dmem_wdata as the byte replicated x4 for SB, the half replicated x2 for SH, and wdata unmodified for SW.
REQ-020 SHALL hold dmem_req=1 in BUSY until a cycle with dmem_ack=1, then register the result and move to DONE.
REQ-021 SHALL select the load byte or half by addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend to 32 bits; stores register rdata=0.
REQ-022 SHALL drive stall=1 in IDLE when start is true, and in BUSY (including the ack cycle); stall=0 otherwise.
REQ-023 SHALL drive out_valid=1 with the registered rdata in DONE for exactly one cycle, ignore inputs in DONE, and return to IDLE.
REQ-024 SHALL, in IDLE with in_valid and no mem_read/mem_write, drive out_valid=1, rdata=0 and stall=0, with no bus request.
REQ-025 SHALL, in IDLE with in_valid and access_err=1, drive out_valid=1 and rdata=0 in the same cycle, with no bus request and no stall.
REQ-026 SHALL ignore dmem_ack in IDLE and DONE.
REQ-027 SHALL drive access_err=0 outside IDLE.
REQ-028 SHALL allow single-cycle ack, giving minimum access latency IDLE->BUSY->DONE = 2 cycles of stall.

Reset
REQ-029 SHALL, on rst, asynchronously enter IDLE with dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, rdata=0, out_valid=0 and stall=0.
REQ-030 SHALL, when rst occurs in BUSY, drop dmem_req immediately and discard any later dmem_ack without updating rdata.

Verification
REQ-031 SHALL verify LB at addr=0x103 with dmem_rdata=0x80FF_1234 and ack after 3 cycles: be=0000, dmem_addr=0x100, stall for 4 cycles, then rdata=0xFFFFFF80 with out_valid for 1 cycle.
REQ-032 SHALL verify SH at addr=0x22 with wdata=0x0000_BEEF: dmem_we=1, be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x20.
REQ-033 SHALL verify LW at addr=0x6 -> access_err=1, out_valid=1, no dmem_req and stall=0 in the same cycle.
REQ-034 SHALL verify LHU at addr=0x2 with dmem_rdata=0xA5A5_0000 and immediate ack -> rdata=0x0000A5A5 and exactly 2 stall cycles.
REQ-035 SHALL verify rst asserted in BUSY followed by dmem_ack -> dmem_req=0 at once, state IDLE, out_valid never asserts and rdata=0.
REQ-036 SHALL verify back-to-back SW then LW with a 1-cycle ack -> two separate requests, one DONE cycle between them, and the second dmem_req only after returning to IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes size/sign, checks alignment,
// runs one data-memory request per access and extends load data.
// Ports:
//   clk, rst              - clock, async active-high reset
//   in_valid, mem_read,
//   mem_write, funct3,
//   addr, wdata           - instruction in the MEM stage
//   stall                 - hold IF/ID/EX/MEM, inputs stay stable
//   out_valid, rdata,
//   access_err            - result strobe, extended load data, fault
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata,
//   dmem_be               - memory request and its fields
//   dmem_ack, dmem_rdata  - completion and raw read word
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] rdata,
  output logic            access_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic            is_load, is_store, is_mem;
  logic            bad_code, misalign;
  logic            err_c, start;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  // Decode; a read+write combination is a load.
  always_comb begin
    is_load  = mem_read;
    is_store = mem_write & ~mem_read;
    is_mem   = is_load | is_store;
    if (is_load)
      bad_code = (funct3 == 3'b011) |
                 (funct3[2:1] == 2'b11);
    else
      bad_code = funct3[2] |
                 (funct3[1:0] == 2'b11);
    misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
               ((funct3[1:0] == 2'b10) & (|addr[1:0]));
    err_c = (state_q == IDLE) & is_mem &
            (bad_code | misalign);
    start = (state_q == IDLE) & ~rst & in_valid &
            is_mem & ~err_c;
  end

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = '0;
    if (is_store) begin
      unique case (1'b1)
        funct3[1:0] == 2'b00: begin
          be_c    = 4'b0001 << addr[1:0];
          wdata_c = {4{wdata[7:0]}};
        end
        funct3[1:0] == 2'b01: begin
          be_c    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = wdata;
        end
      endcase
    end
  end

  // Lane select and extension of the returned word.
  always_comb begin
    ld_byte = 8'(dmem_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? dmem_rdata[31:16]
                       : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    out_valid  = 1'b0;
    rdata      = '0;
    access_err = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = 4'b0000;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          access_err = err_c;
          if (start) begin
            state_d    = BUSY;
            stall      = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = is_store;
            dmem_addr  = {addr[31:2], 2'b00};
            dmem_wdata = wdata_c;
            dmem_be    = be_c;
          end else if (in_valid) begin
            // no memory op, or a faulting one
            out_valid = 1'b1;
          end
        end
        BUSY: begin
          stall      = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = addr_q;
          dmem_wdata = wdata_q;
          dmem_be    = be_q;
          if (dmem_ack) state_d = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          rdata     = rdata_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
        we_q    <= is_store;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
      end
      if (state_q == BUSY && dmem_ack)
        rdata_q <= we_q ? '0 : load_ext;
    end
  end

endmodule
